seq_lock: RTL
=============

SEQ_LOCK -- requirements
Module: seq_lock

Interface
REQ-001 SHALL have parameter SW_W, default 3, switch-group width per code symbol.
REQ-002 SHALL have parameter SEQ_LEN, default 4, number of symbols in the combination (2..16).
REQ-003 SHALL have parameter DEBOUNCE, default 500000, stable-cycle count before a press is accepted.
REQ-004 SHALL have parameter DIGITS, default 3, number of multiplexed 7-segment digits (3..8).
REQ-005 SHALL have parameter SCAN_BIT, default 15, digit advances every 2^(SCAN_BIT+1) cycles.
REQ-006 SHALL have parameter MAX_FAIL, default 3, failed attempts that trigger lockout (1..15).
REQ-007 SHALL have parameter LOCKOUT_CYC, default 100000000, lockout duration in cycles.
REQ-008 SHALL have port clk, input, 1, rising-edge clock.
REQ-009 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-010 SHALL have port btn, input, 1, raw asynchronous enter button, active-high.
REQ-011 SHALL have port sw, input, SW_W, symbol switches, sampled on accepted press.
REQ-012 SHALL have port code, input, SEQ_LEN*SW_W, combination; symbol k = code[k*SW_W +: SW_W], symbol 0 entered first.
REQ-013 SHALL have port anodes, output, DIGITS, active-low digit enables.
REQ-014 SHALL have port cathodes, output, 8, active-low segments {dp,g..a}.
REQ-015 SHALL have ports leds, output, 8; unlocked, output, 1; locked_out, output, 1.

Function
REQ-016 SHALL synchronise btn through two flops; press accepted as one-cycle click when synced btn held high DEBOUNCE consecutive cycles; count saturates until btn low; one click per press.
REQ-017 SHALL implement FSM states ENTER, OPEN, LOCKOUT with symbol index idx (0..SEQ_LEN-1) and fail counter fails (saturating at MAX_FAIL).
REQ-018 In ENTER on click: sw==symbol idx -> idx+1; at idx==SEQ_LEN-1 match -> OPEN, idx 0, fails 0.
REQ-019 In ENTER on mismatch: if idx>0, fails+1; idx <= (sw==symbol 0) ? 1 : 0; if fails reaches MAX_FAIL -> LOCKOUT.
REQ-020 In OPEN: click -> ENTER, idx 0; unlocked=1 and leds=8'hFF while OPEN, registered (one cycle after state entry).
REQ-021 In LOCKOUT: clicks ignored; after LOCKOUT_CYC cycles -> ENTER, idx 0, fails 0; locked_out=1 while in LOCKOUT.
REQ-022 In ENTER, leds SHALL show {fails[3:0], idx[3:0]}, registered.
REQ-023 Scan: free-running counter; anodes rotate right one position when counter[SCAN_BIT:0]==0; exactly one anode low at all times.
REQ-024 Digit 0 = idx, digit 1 = fails, digit 2 = state code (ENTER 0, OPEN 1, LOCKOUT 2); digits >=3 blank (8'hFF).
REQ-025 Cathodes SHALL decode hex 0..F with dp off, combinationally from the selected digit.
REQ-026 Reset SHALL override a simultaneous click or lockout expiry.

Reset
REQ-027 On reset low: state ENTER, idx 0, fails 0, debounce count 0, scan counter 0, anodes = all ones except bit 0 low, leds 0, unlocked 0, locked_out 0.
REQ-028 Reset asserted mid-entry or mid-lockout SHALL abandon progress with no click emitted.

Configuration
REQ-029 Macro SEQ_LOCK_LOCKOUT_EN defined: REQ-019/021 lockout behaviour applies.
REQ-030 Macro undefined: LOCKOUT state and timer absent; fails saturates at MAX_FAIL, FSM stays in ENTER; locked_out tied 0.

Structure
REQ-031 Package seq_lock_pkg SHALL hold the state enum, state display codes and the 16-entry 7-segment table.
REQ-032 Debounce/synchroniser SHALL be sub-module btn_debounce (ports clk, reset, btn, click).

Verification (SW_W=3, SEQ_LEN=4, DEBOUNCE=4, SCAN_BIT=2, MAX_FAIL=3, LOCKOUT_CYC=50, code symbols 1,7,3,5)
REQ-033 Press btn 3 cycles then release -> no click; hold 10 cycles -> exactly one click.
REQ-034 Enter 1,7,3,5 -> state OPEN, unlocked=1, leds=8'hFF; next click -> ENTER, leds 8'h00.
REQ-035 Enter 1,7,1,7,3,5 -> fails=1 after third press, idx=1, then OPEN and fails 0.
REQ-036 Three runs of 1,2 -> locked_out=1 (macro on); clicks ignored; after 50 cycles ENTER, fails 0.
REQ-037 Reset low during idx=2 -> next cycle idx 0, anodes 3'b110, leds 0.
REQ-038 Free-run 64 cycles -> anodes sequence 110,011,101 every 8 cycles; cathodes 8'hC0 for digit 0 when idx=0.

Source files
------------

// File: rtl/seq_lock_pkg.sv
// Shared types and constants for the sequence lock: FSM states, their display
// codes and the active-low 7-segment font.
package seq_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTER   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  localparam logic [3:0] DISP_ENTER   = 4'h0;
  localparam logic [3:0] DISP_OPEN    = 4'h1;
  localparam logic [3:0] DISP_LOCKOUT = 4'h2;

  // Entry k (hex digit k) lives at bits [k*8 +: 8]; format {dp,g..a}, active low.
  localparam logic [127:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    return SEG_TABLE[{v, 3'b000} +: 8];
  endfunction

  function automatic logic [3:0] state_disp(input state_t s);
    case (s)
      ST_ENTER:   return DISP_ENTER;
      ST_OPEN:    return DISP_OPEN;
      ST_LOCKOUT: return DISP_LOCKOUT;
      default:    return DISP_ENTER;
    endcase
  endfunction

endpackage

// File: rtl/seq_lock_debounce.sv
// Two-flop synchroniser plus hold-time debouncer for the enter button;
// emits a single-cycle click per press once the button has been stable.
module btn_debounce #(
  parameter int DEBOUNCE = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic click
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_click;

  // Synchronise the raw button and count stable-high cycles, saturating at DEBOUNCE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_click <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      if (!r_sync2) begin
        r_cnt   <= '0;
        r_click <= 1'b0;
      end else if (r_cnt != CNT_W'(DEBOUNCE)) begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_click <= (r_cnt == CNT_W'(DEBOUNCE - 1));
      end else begin
        r_click <= 1'b0;
      end
    end
  end

  assign click = r_click;

endmodule

// File: rtl/seq_lock.sv
// Combination lock: debounced symbol entry, fail counting, optional lockout
// (enabled by macro SEQ_LOCK_LOCKOUT_EN) and a multiplexed 7-segment status display.
module seq_lock
  import seq_lock_pkg::*;
#(
  parameter int SW_W        = 3,
  parameter int SEQ_LEN     = 4,
  parameter int DEBOUNCE    = 500000,
  parameter int DIGITS      = 3,
  parameter int SCAN_BIT    = 15,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 100000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn,
  input  logic [SW_W-1:0]         sw,
  input  logic [SEQ_LEN*SW_W-1:0] code,
  output logic [DIGITS-1:0]       anodes,
  output logic [7:0]              cathodes,
  output logic [7:0]              leds,
  output logic                    unlocked,
  output logic                    locked_out
);

  logic            w_click;
  state_t          r_state, w_state_n;
  logic [3:0]      r_idx, w_idx_n;
  logic [3:0]      r_fails, w_fails_n;
  logic [SW_W-1:0] w_sym;
  logic [SW_W-1:0] w_sym0;
  logic [7:0]      r_leds;
  logic            r_unlocked;
  logic [SCAN_BIT:0] r_scan;
  logic [DIGITS-1:0] r_anodes;
  logic [2:0]      w_dig;
  logic [7:0]      w_cath;

`ifdef SEQ_LOCK_LOCKOUT_EN
  localparam int TMR_W = $clog2(LOCKOUT_CYC + 1);
  logic [TMR_W-1:0] r_tmr, w_tmr_n;
  logic             r_locked;
`endif

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .click (w_click)
  );

  assign w_sym  = code[r_idx*SW_W +: SW_W];
  assign w_sym0 = code[SW_W-1:0];

  // FSM state, symbol index and fail counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_ENTER;
      r_idx   <= 4'd0;
      r_fails <= 4'd0;
`ifdef SEQ_LOCK_LOCKOUT_EN
      r_tmr   <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_fails <= w_fails_n;
`ifdef SEQ_LOCK_LOCKOUT_EN
      r_tmr   <= w_tmr_n;
`endif
    end
  end

  // Next-state logic for entry, open and lockout.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_fails_n = r_fails;
`ifdef SEQ_LOCK_LOCKOUT_EN
    w_tmr_n   = '0;
`endif
    case (r_state)
      ST_ENTER: begin
        if (!w_click) begin
          w_state_n = ST_ENTER;
        end else if (sw == w_sym) begin
          if (r_idx == 4'(SEQ_LEN - 1)) begin
            w_state_n = ST_OPEN;
            w_idx_n   = 4'd0;
            w_fails_n = 4'd0;
          end else begin
            w_idx_n = r_idx + 4'd1;
          end
        end else begin
          // A wrong first symbol is not an attempt; a wrong symbol may still restart one.
          if (r_idx != 4'd0 && r_fails < 4'(MAX_FAIL)) begin
            w_fails_n = r_fails + 4'd1;
          end else begin
            w_fails_n = r_fails;
          end
          w_idx_n = (sw == w_sym0) ? 4'd1 : 4'd0;
`ifdef SEQ_LOCK_LOCKOUT_EN
          if (r_idx != 4'd0 && w_fails_n == 4'(MAX_FAIL)) begin
            w_state_n = ST_LOCKOUT;
            w_idx_n   = 4'd0;
          end else begin
            w_state_n = ST_ENTER;
          end
`endif
        end
      end
      ST_OPEN: begin
        if (w_click) begin
          w_state_n = ST_ENTER;
          w_idx_n   = 4'd0;
        end else begin
          w_state_n = ST_OPEN;
        end
      end
      ST_LOCKOUT: begin
`ifdef SEQ_LOCK_LOCKOUT_EN
        if (r_tmr == TMR_W'(LOCKOUT_CYC - 1)) begin
          w_state_n = ST_ENTER;
          w_idx_n   = 4'd0;
          w_fails_n = 4'd0;
        end else begin
          w_tmr_n = r_tmr + TMR_W'(1);
        end
`else
        w_state_n = ST_ENTER;
        w_idx_n   = 4'd0;
`endif
      end
      default: begin
        w_state_n = ST_ENTER;
        w_idx_n   = 4'd0;
        w_fails_n = 4'd0;
      end
    endcase
  end

  // Registered status outputs, one cycle behind the FSM state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_leds     <= 8'h00;
      r_unlocked <= 1'b0;
`ifdef SEQ_LOCK_LOCKOUT_EN
      r_locked   <= 1'b0;
`endif
    end else begin
      r_leds     <= (r_state == ST_OPEN) ? 8'hFF : {r_fails, r_idx};
      r_unlocked <= (r_state == ST_OPEN);
`ifdef SEQ_LOCK_LOCKOUT_EN
      r_locked   <= (r_state == ST_LOCKOUT);
`endif
    end
  end

  // Free-running scan counter and one-cold anode rotation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_scan   <= '0;
      r_anodes <= ~DIGITS'(1);
    end else begin
      r_scan <= r_scan + (SCAN_BIT+1)'(1);
      if (r_scan == '0) begin
        r_anodes <= {r_anodes[0], r_anodes[DIGITS-1:1]};
      end else begin
        r_anodes <= r_anodes;
      end
    end
  end

  // Locate the active (low) anode.
  always_comb begin
    w_dig = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!r_anodes[i]) begin
        w_dig = 3'(i);
      end else begin
        w_dig = w_dig;
      end
    end
  end

  // Segment pattern for the selected digit.
  always_comb begin
    case (w_dig)
      3'd0:    w_cath = seg_decode(r_idx);
      3'd1:    w_cath = seg_decode(r_fails);
      3'd2:    w_cath = seg_decode(state_disp(r_state));
      default: w_cath = SEG_BLANK;
    endcase
  end

  assign anodes   = r_anodes;
  assign cathodes = w_cath;
  assign leds     = r_leds;
  assign unlocked = r_unlocked;
`ifdef SEQ_LOCK_LOCKOUT_EN
  assign locked_out = r_locked;
`else
  assign locked_out = 1'b0;
`endif

endmodule
